// File: rtl/ds_frame_ctrl.sv
// ds_frame_ctrl: frame-capture sequencer for the decimate-by-10 peak-hold
// downsampler. A start command holds the downsampler in reset for one cycle,
// releases it at the start of RUN so its window counter lines up with frame
// word 0, and gates its sample enable from the ADC strobe. Each rising edge of
// the downsampler's output-valid writes one word to the frame RAM. After
// FRAME_LEN words the downsampler is parked again and done pulses for one cycle.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      one-cycle capture request / cancel (abort wins)
//   adc_valid         ADC sample strobe
//   ds_rst, ds_ena    downsampler reset and sample enable (ds_ena combinational)
//   ds_busy           downsampler outbusy, suppresses its out_en outside RUN
//   ds_out_en,ds_data downsampler output-valid and signed 12-bit word
//   wr_en/addr/data   frame RAM write port, one cycle after word acceptance
//   busy, done        capture in progress / one-cycle frame-complete pulse
//   frame_peak        signed max of the last completed frame
//
// Build option: define DS_FRAME_PEAK_EN to enable the frame peak tracker;
// otherwise frame_peak is tied to 0.
module ds_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     adc_valid,
  output logic                     ds_rst,
  output logic                     ds_ena,
  output logic                     ds_busy,
  input  logic                     ds_out_en,
  input  logic signed [11:0]       ds_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [11:0]       wr_data,
  output logic                     busy,
  output logic                     done,
  output logic signed [11:0]       frame_peak
);

  // One extra counter bit so FRAME_LEN = 2^ADDR_W is representable.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             oe_q;
  logic             accept_c;
  logic             last_c;
  logic             ds_rst_d, ds_busy_d, busy_d, done_d;

  // The downsampler holds out_en between sparse enables, so only its rising
  // edge marks a new word. A cycle carrying abort accepts nothing.
  always_comb begin
    accept_c = (state_q == RUN) && ds_out_en && !oe_q && !abort;
    last_c   = accept_c && (cnt_q == LAST_IDX);
  end

  // Next state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    ds_rst_d  = 1'b1;
    ds_busy_d = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM:  state_d = RUN;
      RUN:  if (last_c) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;

    unique case (state_d)
      IDLE: ;
      ARM:  busy_d = 1'b1;
      RUN: begin
        ds_rst_d  = 1'b0;
        ds_busy_d = 1'b0;
        busy_d    = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
    endcase
  end

  // Sample enable follows the ADC strobe only while running.
  assign ds_ena = (state_q == RUN) && adc_valid;

  // State and control-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ds_rst  <= 1'b1;
      ds_busy <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ds_rst  <= ds_rst_d;
      ds_busy <= ds_busy_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Word counter, edge register and frame RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept_c;
      oe_q  <= (state_q == ARM) ? 1'b0 : ds_out_en;
      if (accept_c) begin
        wr_addr <= cnt_q[ADDR_W-1:0];
        wr_data <= ds_data;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (state_q == ARM) cnt_q <= '0;
    end
  end

`ifdef DS_FRAME_PEAK_EN
  logic signed [11:0] peak_q;
  logic signed [11:0] peak_next_c;

  always_comb begin
    peak_next_c = peak_q;
    if (accept_c && (ds_data > peak_q)) peak_next_c = ds_data;
  end

  // Running max restarts at the most negative value; published on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= 12'sh800;
      frame_peak <= '0;
    end else begin
      peak_q <= (state_q == ARM) ? 12'sh800 : peak_next_c;
      if (last_c) frame_peak <= peak_next_c;
    end
  end
`else
  assign frame_peak = '0;
`endif

endmodule

// File: tb/tb_ds_frame_ctrl.sv
// Self-checking bench for ds_frame_ctrl (FRAME_LEN=4): reset/idle checks, a
// table of cycle vectors for frame, abort and start/abort corner cases, then
// randomized frames against a window-max reference computed from the ADC stream.
module tb_ds_frame_ctrl;

  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned ADDR_W    = 8;
`ifdef DS_FRAME_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, abort, adc_valid;
  logic ds_rst, ds_ena, ds_busy, ds_out_en;
  logic signed [11:0] ds_data;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic signed [11:0] wr_data;
  logic busy, done;
  logic signed [11:0] frame_peak;

  // Table-driven or behavioural-downsampler source for ds_out_en/ds_data.
  logic use_model;
  logic t_oe;
  logic signed [11:0] t_d;
  logic m_oe;
  logic signed [11:0] m_d, m_acc, adc_data;
  int m_cnt;

  assign ds_out_en = use_model ? m_oe : t_oe;
  assign ds_data   = use_model ? m_d  : t_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ds_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .adc_valid(adc_valid),
    .ds_rst(ds_rst), .ds_ena(ds_ena), .ds_busy(ds_busy),
    .ds_out_en(ds_out_en), .ds_data(ds_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .frame_peak(frame_peak)
  );

  function automatic logic signed [11:0] smax(logic signed [11:0] a, logic signed [11:0] b);
    return (a > b) ? a : b;
  endfunction

  // Peak-hold decimator: every 10th enable presents the window max and holds
  // out_en until the next enable.
  always @(posedge clk) begin
    if (ds_rst) begin
      m_cnt <= 0;
      m_oe  <= 1'b0;
      m_d   <= '0;
      m_acc <= 12'sh800;
    end else if (ds_ena) begin
      if (m_cnt == 9) begin
        m_oe  <= !ds_busy;
        m_d   <= smax(m_acc, adc_data);
        m_cnt <= 0;
        m_acc <= 12'sh800;
      end else begin
        m_oe  <= 1'b0;
        m_cnt <= m_cnt + 1;
        m_acc <= smax(m_acc, adc_data);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic st, ab, av, oe;
    int   d;
    logic e_busy, e_done, e_rst, e_ena, e_wen;
    int   e_addr, e_wdata, e_pk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int st, int ab, int av, int oe, int d,
                              int eb, int edn, int er, int ee, int ew,
                              int ea, int ewd, int epk);
    vec_t v;
    v.st = st[0]; v.ab = ab[0]; v.av = av[0]; v.oe = oe[0]; v.d = d;
    v.e_busy = eb[0]; v.e_done = edn[0]; v.e_rst = er[0]; v.e_ena = ee[0];
    v.e_wen = ew[0]; v.e_addr = ea; v.e_wdata = ewd; v.e_pk = epk;
    return v;
  endfunction

  initial begin
    logic signed [11:0] samples[$];
    int w_addr[$];
    int w_data[$];
    int density, done_cnt, done_wen, done_addr, ena_bad, k;
    bit finished;
    logic signed [11:0] exp_w, exp_pk;

    // Inputs, then outputs as they appear during that row (before its edge).
    //             st ab av oe d      busy done rst ena wen addr wdata pk
    tbl.push_back(mk(0,0,0,0,0,     0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(1,0,1,0,0,     0,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,0,0,     1,0,1,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,0,0,     1,0,0,1,0, 0,0,0));
    tbl.push_back(mk(0,0,0,1,-5,    1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,1,100,   1,0,0,1,1, 0,-5,0));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,1,300,   1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,0,1, 1,300,0));
    tbl.push_back(mk(0,0,0,1,-2048, 1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,0,1, 2,-2048,0));
    tbl.push_back(mk(1,0,1,1,17,    1,0,0,1,0, 0,0,0));
    tbl.push_back(mk(0,0,1,1,17,    1,1,1,0,1, 3,17,300));
    tbl.push_back(mk(0,0,0,0,0,     0,0,1,0,0, 0,0,300));
    tbl.push_back(mk(1,0,0,0,0,     0,0,1,0,0, 0,0,300));
    tbl.push_back(mk(0,0,0,0,0,     1,0,1,0,0, 0,0,300));
    tbl.push_back(mk(0,0,0,1,11,    1,0,0,0,0, 0,0,300));
    tbl.push_back(mk(0,0,0,0,0,     1,0,0,0,1, 0,11,300));
    tbl.push_back(mk(0,0,0,1,22,    1,0,0,0,0, 0,0,300));
    tbl.push_back(mk(0,1,0,0,0,     1,0,0,0,1, 1,22,300));
    tbl.push_back(mk(0,0,1,1,33,    0,0,1,0,0, 0,0,300));
    tbl.push_back(mk(0,0,0,0,0,     0,0,1,0,0, 0,0,300));
    tbl.push_back(mk(1,1,0,0,0,     0,0,1,0,0, 0,0,300));
    tbl.push_back(mk(0,0,0,0,0,     0,0,1,0,0, 0,0,300));
    tbl.push_back(mk(1,0,0,0,0,     0,0,1,0,0, 0,0,300));
    tbl.push_back(mk(0,1,0,0,0,     1,0,1,0,0, 0,0,300));
    tbl.push_back(mk(0,0,0,0,0,     0,0,1,0,0, 0,0,300));

    rst = 1'b1; start = 1'b0; abort = 1'b0; adc_valid = 1'b0; adc_data = '0;
    use_model = 1'b0; t_oe = 1'b0; t_d = '0;

    // Reset hold then idle.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      if (i >= 1) begin
        chk("idle_ds_rst", int'(ds_rst), 1);
        chk("idle_ds_busy", int'(ds_busy), 1);
        chk("idle_ds_ena", int'(ds_ena), 0);
        chk("idle_wr_en", int'(wr_en), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_frame_peak", int'(frame_peak), 0);
      end
    end

    // Vector table.
    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].st; abort = tbl[i].ab; adc_valid = tbl[i].av;
      t_oe = tbl[i].oe; t_d = 12'(tbl[i].d);
      #1;
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("vec%0d_ds_rst", i), int'(ds_rst), int'(tbl[i].e_rst));
      chk($sformatf("vec%0d_ds_busy", i), int'(ds_busy), int'(tbl[i].e_rst));
      chk($sformatf("vec%0d_ds_ena", i), int'(ds_ena), int'(tbl[i].e_ena));
      chk($sformatf("vec%0d_wr_en", i), int'(wr_en), int'(tbl[i].e_wen));
      if (tbl[i].e_wen) begin
        chk($sformatf("vec%0d_wr_addr", i), int'(wr_addr), tbl[i].e_addr);
        chk($sformatf("vec%0d_wr_data", i), int'(wr_data), tbl[i].e_wdata);
      end
      chk($sformatf("vec%0d_frame_peak", i), int'(frame_peak), PEAK_EN ? tbl[i].e_pk : 0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; adc_valid = 1'b0; t_oe = 1'b0;

    // Randomized frames through the behavioural downsampler.
    use_model = 1'b1;
    repeat (3) @(negedge clk);
    for (int trial = 0; trial < 8; trial++) begin
      density = (trial < 2) ? 1 : ((trial < 4) ? 3 : int'($urandom_range(1, 4)));
      samples.delete(); w_addr.delete(); w_data.delete();
      done_cnt = 0; done_wen = 0; done_addr = -1; ena_bad = 0; finished = 1'b0;
      k = 0;
      while (!finished && k < 2000) begin
        @(negedge clk);
        if (k > 0) begin
          if (wr_en) begin
            w_addr.push_back(int'(wr_addr));
            w_data.push_back(int'(wr_data));
          end
          if (ds_ena && ds_rst) ena_bad++;
          if (done) begin
            done_cnt++; done_wen = int'(wr_en); done_addr = int'(wr_addr);
            finished = 1'b1;
          end
        end
        start = (k == 0) || (k == 17);
        adc_valid = ($urandom_range(1, density) == 1);
        adc_data = 12'($urandom);
        if (k >= 2 && adc_valid && samples.size() < 10 * FRAME_LEN)
          samples.push_back(adc_data);
        k++;
      end
      start = 1'b0; adc_valid = 1'b0;
      chk($sformatf("rnd%0d_completed", trial), int'(finished), 1);
      chk($sformatf("rnd%0d_write_count", trial), w_addr.size(), FRAME_LEN);
      exp_pk = 12'sh800;
      for (int w = 0; w < FRAME_LEN; w++) begin
        exp_w = 12'sh800;
        for (int s = 0; s < 10; s++)
          if (10 * w + s < samples.size()) exp_w = smax(exp_w, samples[10 * w + s]);
        exp_pk = smax(exp_pk, exp_w);
        if (w < w_addr.size()) begin
          chk($sformatf("rnd%0d_addr%0d", trial, w), w_addr[w], w);
          chk($sformatf("rnd%0d_data%0d", trial, w), w_data[w], int'(exp_w));
        end
      end
      chk($sformatf("rnd%0d_done_count", trial), done_cnt, 1);
      chk($sformatf("rnd%0d_done_with_write", trial), done_wen, 1);
      chk($sformatf("rnd%0d_done_addr", trial), done_addr, FRAME_LEN - 1);
      chk($sformatf("rnd%0d_ena_in_reset", trial), ena_bad, 0);
      chk($sformatf("rnd%0d_frame_peak", trial), int'(frame_peak), PEAK_EN ? int'(exp_pk) : 0);
      @(negedge clk);
      chk($sformatf("rnd%0d_post_ds_rst", trial), int'(ds_rst), 1);
      chk($sformatf("rnd%0d_post_busy", trial), int'(busy), 0);
      chk($sformatf("rnd%0d_post_wr_en", trial), int'(wr_en), 0);
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
